spike_synth: RTL and testbench

Synthetic neural-signal generator, the inverse of the spike detector. It converts spike trigger events into a 16-bit signed sample stream carrying biphasic spike waveforms on a programmable baseline. It sits ahead of the detection chain for loopback self-test and for bench stimulus. Its output connects directly to the detector's data input. One spike is rendered per accepted trigger. Triggers that arrive during a spike or its refractory window are dropped and counted.

---
 rtl/spike_synth_if.sv | 23 ++
 rtl/spike_synth.sv | 169 ++++++++++++++++
 tb/tb_spike_synth.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spike_synth_if.sv
// Stimulus/sample bus between a spike_synth generator and whatever drives and consumes it.
// The master drives trigger, strobe and shape controls; the slave (the generator) returns the sample stream.
interface spike_synth_if;
    logic               sample_en;
    logic               trig;
    logic signed [15:0] amplitude;
    logic signed [15:0] baseline;
    logic signed [15:0] data_out;
    logic               data_valid;
    logic               spike_start;
    logic               busy;
    logic [7:0]         drop_cnt;

    modport master (
        output sample_en, trig, amplitude, baseline,
        input  data_out, data_valid, spike_start, busy, drop_cnt
    );

    modport slave (
        input  sample_en, trig, amplitude, baseline,
        output data_out, data_valid, spike_start, busy, drop_cnt
    );
endinterface

// File: rtl/spike_synth.sv
// Synthetic biphasic spike generator: one NEG/POS/REFRAC waveform per accepted trigger on a baseline.
// Optional additive LFSR noise is enabled by defining SPIKE_SYNTH_NOISE_EN.
module spike_synth #(
    parameter int NEG_LEN     = 4,
    parameter int POS_LEN     = 8,
    parameter int REFRAC      = 20,
    parameter int NOISE_SHIFT = 8
) (
    input  logic           clk,
    input  logic           rst,
    spike_synth_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NEG,
        ST_POS,
        ST_REFRAC
    } state_t;

    localparam int MAX_AB  = (NEG_LEN > POS_LEN) ? NEG_LEN : POS_LEN;
    localparam int MAX_LEN = (MAX_AB > REFRAC) ? MAX_AB : REFRAC;
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] NEG_LAST    = CW'(NEG_LEN - 1);
    localparam logic [CW-1:0] POS_LAST    = CW'(POS_LEN - 1);
    localparam logic [CW-1:0] REFRAC_LAST = CW'((REFRAC > 0) ? REFRAC - 1 : 0);

    // State names the phase of the next sample to be produced; phase_cnt is its index in that phase.
    state_t             state;
    logic [CW-1:0]      phase_cnt;
    logic               pending;
    logic [7:0]         drop_q;
    logic signed [15:0] data_q;
    logic               valid_q;
    logic               start_q;

    logic signed [17:0] base_x;
    logic signed [17:0] amp_x;
    logic signed [17:0] half_x;
    logic signed [17:0] noise_x;
    logic signed [15:0] neg_val;
    logic signed [15:0] pos_val;
    logic signed [15:0] base_val;
    logic               start;
    logic               drop;

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sh7FFF;
        else if (v < -18'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

`ifdef SPIKE_SYNTH_NOISE_EN
    logic [15:0]        lfsr;
    logic signed [15:0] noise16;
    logic               lfsr_fb;

    assign noise16 = $signed(lfsr) >>> NOISE_SHIFT;
    assign noise_x = $signed({{2{noise16[15]}}, noise16});
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Fibonacci LFSR, taps 16,14,13,11; the current sample uses the pre-advance value.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 16'hACE1;
        else if (bus.sample_en)
            lfsr <= {lfsr[14:0], lfsr_fb};
    end
`else
    // Without noise NOISE_SHIFT has no effect; referencing it keeps the parameter list uniform.
    localparam int unused_noise_shift = NOISE_SHIFT;
    assign noise_x = '0;
`endif

    assign base_x   = $signed({{2{bus.baseline[15]}}, bus.baseline});
    assign amp_x    = $signed({{2{bus.amplitude[15]}}, bus.amplitude});
    assign half_x   = amp_x >>> 1;
    assign neg_val  = sat16(base_x - amp_x + noise_x);
    assign pos_val  = sat16(base_x + half_x + noise_x);
    assign base_val = sat16(base_x + noise_x);

    assign start = bus.sample_en && (state == ST_IDLE) && (pending || bus.trig);
    assign drop  = bus.trig && ((state != ST_IDLE) || pending);

    assign bus.data_out    = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.spike_start = start_q;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.drop_cnt    = drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            pending   <= 1'b0;
            drop_q    <= 8'd0;
            data_q    <= 16'sd0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            valid_q <= bus.sample_en;
            start_q <= start;

            if (drop && (drop_q != 8'hFF))
                drop_q <= drop_q + 8'd1;

            // A trigger between strobes is remembered until the next sample edge starts the spike.
            if ((state == ST_IDLE) && bus.trig && !bus.sample_en)
                pending <= 1'b1;
            else if (start)
                pending <= 1'b0;

            if (bus.sample_en) begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            data_q <= neg_val;
                            if (NEG_LEN == 1) begin
                                state     <= ST_POS;
                                phase_cnt <= '0;
                            end else begin
                                state     <= ST_NEG;
                                phase_cnt <= CW'(1);
                            end
                        end else begin
                            data_q <= base_val;
                        end
                    end
                    ST_NEG: begin
                        data_q <= neg_val;
                        if (phase_cnt == NEG_LAST) begin
                            state     <= ST_POS;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + CW'(1);
                        end
                    end
                    ST_POS: begin
                        data_q <= pos_val;
                        if (phase_cnt == POS_LAST) begin
                            state     <= (REFRAC == 0) ? ST_IDLE : ST_REFRAC;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + CW'(1);
                        end
                    end
                    ST_REFRAC: begin
                        data_q <= base_val;
                        if (phase_cnt == REFRAC_LAST) begin
                            state     <= ST_IDLE;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + CW'(1);
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        phase_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spike_synth.sv
// Self-checking bench for spike_synth: directed scenarios plus randomized traffic against an index-based waveform model.
// The noise model is active when SPIKE_SYNTH_NOISE_EN is defined for the build.
module tb_spike_synth;

    localparam int NEG_LEN     = 4;
    localparam int POS_LEN     = 8;
    localparam int REFRAC      = 20;
    localparam int NOISE_SHIFT = 8;
    localparam int TOTAL       = NEG_LEN + POS_LEN + REFRAC;

    logic clk = 1'b0;
    logic rst;

    spike_synth_if bus ();

    spike_synth #(
        .NEG_LEN    (NEG_LEN),
        .POS_LEN    (POS_LEN),
        .REFRAC     (REFRAC),
        .NOISE_SHIFT(NOISE_SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: m_idx is the spike-relative index of the next sample, -1 when no spike is in flight.
    int m_idx     = -1;
    bit m_pending = 1'b0;
    int m_drops   = 0;
    int m_out     = 0;
    bit m_valid   = 1'b0;
    bit m_start   = 1'b0;
`ifdef SPIKE_SYNTH_NOISE_EN
    logic [15:0] m_lfsr = 16'hACE1;
`endif

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int shape(input int k, input int a, input int b);
        if (k < NEG_LEN)           return b - a;
        if (k < NEG_LEN + POS_LEN) return b + (a >>> 1);
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit se, input bit tr, input int a, input int b);
        int noise;
        bit idle;
        if (r) begin
            m_idx = -1; m_pending = 0; m_drops = 0; m_out = 0; m_valid = 0; m_start = 0;
`ifdef SPIKE_SYNTH_NOISE_EN
            m_lfsr = 16'hACE1;
`endif
            return;
        end
        m_valid = se;
        m_start = 0;
        idle    = (m_idx < 0);
        if (tr && (!idle || m_pending) && m_drops < 255) m_drops++;
        if (!se) begin
            if (idle && tr) m_pending = 1;
            return;
        end
        noise = 0;
`ifdef SPIKE_SYNTH_NOISE_EN
        noise  = int'($signed(m_lfsr)) >>> NOISE_SHIFT;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
        if (idle && !(m_pending || tr)) begin
            m_out = sat16(b + noise);
        end else begin
            if (idle) begin
                m_idx = 0; m_start = 1; m_pending = 0;
            end
            m_out = sat16(shape(m_idx, a, b) + noise);
            m_idx++;
            if (m_idx == TOTAL) m_idx = -1;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit se, input bit tr, input int a, input int b);
        rst           = r;
        bus.sample_en = se;
        bus.trig      = tr;
        bus.amplitude = 16'(a);
        bus.baseline  = 16'(b);
        @(posedge clk);
        modelStep(r, se, tr, a, b);
        #1;
        checkOutput("data_out",    $signed(bus.data_out), m_out);
        checkOutput("data_valid",  bus.data_valid, m_valid);
        checkOutput("spike_start", bus.spike_start, m_start);
        checkOutput("busy",        bus.busy, (m_idx >= 0));
        checkOutput("drop_cnt",    bus.drop_cnt, m_drops);
        @(negedge clk);
    endtask

    task automatic runRejectSpike(input int period, input int a, input int b);
        bit se, tr;
        for (int c = 0; c < (TOTAL + 3) * period; c++) begin
            se = ((c % period) == 0);
            tr = (c == 0) || (se && (m_idx == NEG_LEN + 2 || m_idx == TOTAL - 1));
            applyStimulus(0, se, tr, a, b);
        end
    endtask

    initial begin
        int starts;
        int maxAbs;
        int a, b;
        bit se, tr, r;

        rst = 1'b1;
        bus.sample_en = 0; bus.trig = 0; bus.amplitude = '0; bus.baseline = '0;
        @(negedge clk);

        // Reset state
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1000, 0);
        checkOutput("reset_out",  $signed(bus.data_out), 0);
        checkOutput("reset_busy", bus.busy, 0);

        // Nominal spike, strobe every 4th cycle
        starts = 0;
        for (int c = 0; c < 40 * 4; c++) begin
            applyStimulus(0, (c % 4) == 3, c == 1, 1000, 0);
            if (bus.spike_start) starts++;
        end
        checkOutput("nominal_starts", starts, 1);
        checkOutput("nominal_drops", bus.drop_cnt, 0);

        // Saturation in both directions
        for (int c = 0; c < (TOTAL + 4) * 2; c++)
            applyStimulus(0, (c % 2) == 0, c == 0, 5000, -30000);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, 1, c == 0, -6000, 30000);
            if (c < NEG_LEN) checkOutput("sat_neg_hi", $signed(bus.data_out), 32767);
        end
        for (int c = 0; c < TOTAL; c++) applyStimulus(0, 1, 0, -6000, 30000);

        // Same-edge start
        applyStimulus(0, 1, 1, 1234, 100);
        checkOutput("same_edge_out",   $signed(bus.data_out), -1134);
        checkOutput("same_edge_start", bus.spike_start, 1);
        checkOutput("same_edge_valid", bus.data_valid, 1);
        for (int c = 0; c < TOTAL + 2; c++) applyStimulus(0, 1, 0, 1234, 100);

        // Rejection during POS and on the final REFRAC edge
        applyStimulus(1, 0, 0, 0, 0);
        runRejectSpike(3, 2000, -100);
        checkOutput("reject_drops", bus.drop_cnt, 2);
        for (int c = 0; c < TOTAL + 3; c++) applyStimulus(0, 1, c == 1, 700, 10);
        for (int n = 0; n < 300; n++) runRejectSpike(1, 900, 5);
        checkOutput("drop_saturate", bus.drop_cnt, 255);

        // Reset on the second NEG sample
        applyStimulus(0, 0, 1, 800, 50);
        applyStimulus(0, 1, 0, 800, 50);
        applyStimulus(0, 1, 0, 800, 50);
        applyStimulus(1, 1, 0, 800, 50);
        checkOutput("midrst_out",  $signed(bus.data_out), 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_drop", bus.drop_cnt, 0);
        for (int c = 0; c < 6; c++) applyStimulus(0, 1, 0, 800, 50);
        applyStimulus(0, 0, 1, 800, 50);
        applyStimulus(1, 0, 0, 800, 50);
        for (int c = 0; c < 6; c++) applyStimulus(0, 1, 0, 800, 50);
        checkOutput("pending_cleared", bus.busy, 0);

        // Noise-only run: zero baseline and amplitude
        applyStimulus(1, 0, 0, 0, 0);
        maxAbs = 0;
        for (int c = 0; c < 300; c++) begin
            applyStimulus(0, 1, 0, 0, 0);
            if ($signed(bus.data_out) > maxAbs)  maxAbs = $signed(bus.data_out);
            if (-$signed(bus.data_out) > maxAbs) maxAbs = -$signed(bus.data_out);
        end
        checkOutput("noise_bound", (maxAbs <= 128), 1);

        // Randomized traffic
        a = 1000; b = 0;
        for (int c = 0; c < 4000; c++) begin
            se = ($urandom_range(0, 2) == 0);
            tr = ($urandom_range(0, 24) == 0);
            r  = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 7) == 0) a = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 7) == 0) b = int'($urandom_range(0, 65535)) - 32768;
            applyStimulus(r, se, tr, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
